// File: rtl/instruction_fetch_mem_pkg.sv
// Shared widths, depth and the NOP encoding for the instruction store and its fetch path.
// Constants only: no latency or flow-control behaviour lives here.
package instruction_fetch_mem_pkg;
  localparam int INSTRUCTION_WIDTH = 32;
  localparam int INSTRUCTION_DEPTH = 1024;
  localparam int PC_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction
endpackage

// File: rtl/instruction_fetch_mem_bank.sv
// One instruction bank: single write port plus a registered read port that only updates when re is high.
// Read data appears 1 cycle after re and holds otherwise; no backpressure of its own.
module imem_bank
  import instruction_fetch_mem_pkg::*;
#(
  parameter int XLEN = INSTRUCTION_WIDTH,
  parameter int BD = INSTRUCTION_DEPTH,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);
  localparam int BAW = (BD > 1) ? $clog2(BD) : 1;

  logic [XLEN-1:0] mem [BD];

  // Storage is deliberately outside the reset domain so a program survives rstn.
  always_ff @(posedge clk) begin
    if (we && (32'(waddr) < 32'(BD))) mem[waddr[BAW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata <= '0;
    else if (re) rdata <= (32'(raddr) < 32'(BD)) ? mem[raddr[BAW-1:0]] : '0;
  end
endmodule

// File: rtl/instruction_fetch_mem.sv
// Instruction store: returns FETCH_N consecutive words per accepted fetch, flags misaligned/out-of-range PCs.
// 1-cycle response latency; response held while rsp_ready=0, req_ready drops on hold or during a load.
module instruction_fetch_mem
  import instruction_fetch_mem_pkg::*;
#(
  parameter int XLEN = INSTRUCTION_WIDTH,
  parameter int DEPTH = INSTRUCTION_DEPTH,
  parameter int FETCH_N = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    ld_en,
  input  logic [AW-1:0]           ld_addr,
  input  logic [XLEN-1:0]         ld_data,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [PC_WIDTH-1:0]     req_pc,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FETCH_N*XLEN-1:0] rsp_data,
  output logic [1:0]              rsp_cnt,
  output logic [PC_WIDTH-1:0]     rsp_pc,
  output logic                    rsp_err,
  output logic [31:0]             fetch_cnt
);
  localparam int BD = ceil_div(DEPTH, FETCH_N);
  localparam logic [XLEN-1:0] NOP = XLEN'(NOP_INSTR);

  logic          accept, bad_pc, ld_ok;
  logic [AW-1:0] idx;
  logic [1:0]    good_cnt;

  assign req_ready = !ld_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign idx       = req_pc[AW+1:2];
  assign bad_pc    = (req_pc[1:0] != 2'b00) || ({2'b00, req_pc[PC_WIDTH-1:2]} >= 32'(DEPTH));
  assign ld_ok     = ld_en && (32'(ld_addr) < 32'(DEPTH));

  if (FETCH_N == 1) begin : g_one
    logic [XLEN-1:0] q0;

    imem_bank #(.XLEN(XLEN), .BD(BD), .AW(AW)) u_bank (
      .clk(clk), .rstn(rstn), .we(ld_ok), .waddr(ld_addr), .wdata(ld_data),
      .re(accept && !bad_pc), .raddr(idx), .rdata(q0)
    );

    assign good_cnt = 2'd1;
    assign rsp_data = rsp_err ? NOP : q0;
  end else begin : g_two
    logic [XLEN-1:0] q0, q1;
    logic [AW-1:0]   half, half_nx;
    logic            last_word, rsp_swap, rsp_last;

    // Even words live in bank 0, odd in bank 1; an odd start PC takes its second word from the next even row.
    assign half      = idx >> 1;
    assign half_nx   = half + AW'(1);
    assign last_word = 32'(idx) == 32'(DEPTH - 1);
    assign good_cnt  = last_word ? 2'd1 : 2'd2;

    imem_bank #(.XLEN(XLEN), .BD(BD), .AW(AW)) u_even (
      .clk(clk), .rstn(rstn), .we(ld_ok && !ld_addr[0]), .waddr(ld_addr >> 1), .wdata(ld_data),
      .re(accept && !bad_pc), .raddr(idx[0] ? half_nx : half), .rdata(q0)
    );
    imem_bank #(.XLEN(XLEN), .BD(BD), .AW(AW)) u_odd (
      .clk(clk), .rstn(rstn), .we(ld_ok && ld_addr[0]), .waddr(ld_addr >> 1), .wdata(ld_data),
      .re(accept && !bad_pc), .raddr(half), .rdata(q1)
    );

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rsp_swap <= 1'b0;
        rsp_last <= 1'b0;
      end else if (accept) begin
        rsp_swap <= idx[0];
        rsp_last <= last_word;
      end
    end

    always_comb begin
      rsp_data = {q1, q0};
      if (rsp_err) begin
        rsp_data = {NOP, NOP};
      end else begin
        if (rsp_swap) rsp_data = {q0, q1};
        if (rsp_last) rsp_data[2*XLEN-1:XLEN] = NOP;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_cnt   <= 2'd0;
      rsp_pc    <= '0;
      rsp_err   <= 1'b0;
      fetch_cnt <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_cnt   <= bad_pc ? 2'd0 : good_cnt;
      rsp_pc    <= req_pc;
      rsp_err   <= bad_pc;
      if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Scoreboard bench: FETCH_N=1 and FETCH_N=2 instances share stimulus; a negedge monitor checks both
// against an array model of the program store and a queue of expected responses.
module tb_instruction_fetch_mem;
  localparam int DEPTH = 1024;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  cnt;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready1, req_ready2, rsp_valid1, rsp_valid2, rsp_err1, rsp_err2;
  logic [31:0] rsp_data1;
  logic [63:0] rsp_data2;
  logic [1:0]  rsp_cnt1, rsp_cnt2;
  logic [31:0] rsp_pc1, rsp_pc2, fetch_cnt1, fetch_cnt2;

  int   total = 0, bad = 0, n_acc = 0, last_tries = 0;
  bit   mon_en = 1'b0, bp_en = 1'b0;
  logic exp_rdy_m;
  logic [31:0] mem_m [DEPTH];
  exp_t q1[$], q2[$];

  always #5 clk = ~clk;

  instruction_fetch_mem #(.XLEN(32), .DEPTH(DEPTH), .FETCH_N(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready1), .req_pc(req_pc),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_data(rsp_data1), .rsp_cnt(rsp_cnt1),
    .rsp_pc(rsp_pc1), .rsp_err(rsp_err1), .fetch_cnt(fetch_cnt1));

  instruction_fetch_mem #(.XLEN(32), .DEPTH(DEPTH), .FETCH_N(2)) u_dut2 (
    .clk(clk), .rstn(rstn), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .req_valid(req_valid), .req_ready(req_ready2), .req_pc(req_pc),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_data(rsp_data2), .rsp_cnt(rsp_cnt2),
    .rsp_pc(rsp_pc2), .rsp_err(rsp_err2), .fetch_cnt(fetch_cnt2));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected response straight from the addressing rules, using the model memory at accept time.
  function automatic exp_t model(input int n, input logic [31:0] pc);
    exp_t e;
    int idx;
    idx = int'(pc >> 2);
    e.pc = pc;
    e.data = '0;
    if (pc[1:0] != 2'b00 || idx >= DEPTH) begin
      e.err = 1'b1;
      e.cnt = 2'd0;
      e.data[31:0] = NOP;
      if (n == 2) e.data[63:32] = NOP;
    end else begin
      e.err = 1'b0;
      e.cnt = 2'd1;
      e.data[31:0] = mem_m[idx];
      if (n == 2) begin
        if (idx + 1 < DEPTH) begin
          e.data[63:32] = mem_m[idx + 1];
          e.cnt = 2'd2;
        end else begin
          e.data[63:32] = NOP;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rsp_valid1", 64'(rsp_valid1), 64'(q1.size() != 0));
      chk("rsp_valid2", 64'(rsp_valid2), 64'(q2.size() != 0));
      if (q1.size() != 0) begin
        chk("rsp_data1", 64'(rsp_data1), q1[0].data);
        chk("rsp_cnt1", 64'(rsp_cnt1), 64'(q1[0].cnt));
        chk("rsp_err1", 64'(rsp_err1), 64'(q1[0].err));
        chk("rsp_pc1", 64'(rsp_pc1), 64'(q1[0].pc));
      end
      if (q2.size() != 0) begin
        chk("rsp_data2", rsp_data2, q2[0].data);
        chk("rsp_cnt2", 64'(rsp_cnt2), 64'(q2[0].cnt));
        chk("rsp_err2", 64'(rsp_err2), 64'(q2[0].err));
        chk("rsp_pc2", 64'(rsp_pc2), 64'(q2[0].pc));
      end
      chk("fetch_cnt1", 64'(fetch_cnt1), 64'(n_acc));
      chk("fetch_cnt2", 64'(fetch_cnt2), 64'(n_acc));
      exp_rdy_m = !ld_en && (q1.size() == 0 || rsp_ready);
      chk("req_ready1", 64'(req_ready1), 64'(exp_rdy_m));
      chk("req_ready2", 64'(req_ready2), 64'(exp_rdy_m));
      if (q1.size() != 0 && rsp_ready) begin
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (ld_en) mem_m[ld_addr] = ld_data;
      if (req_valid && exp_rdy_m) begin
        q1.push_back(model(1, req_pc));
        q2.push_back(model(2, req_pc));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    if (bp_en) rsp_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic load(input logic [9:0] a, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  // Leaves req_valid high so consecutive calls issue back-to-back requests.
  task automatic fetch(input logic [31:0] pc);
    bit acc;
    acc = 1'b0;
    last_tries = 0;
    req_valid = 1'b1;
    req_pc = pc;
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready1;
      last_tries++;
      tick();
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout pc=%h", pc);
    end
  endtask

  task automatic drain();
    req_valid = 1'b0;
    bp_en = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && q1.size() != 0; i++) tick();
    tick();
    if (q1.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout pending=%0d", q1.size());
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_rsp_valid1"}, 64'(rsp_valid1), 64'(0));
    chk({tag, "_rsp_data1"}, 64'(rsp_data1), 64'(0));
    chk({tag, "_rsp_cnt1"}, 64'(rsp_cnt1), 64'(0));
    chk({tag, "_rsp_pc1"}, 64'(rsp_pc1), 64'(0));
    chk({tag, "_rsp_err1"}, 64'(rsp_err1), 64'(0));
    chk({tag, "_fetch_cnt1"}, 64'(fetch_cnt1), 64'(0));
    chk({tag, "_rsp_valid2"}, 64'(rsp_valid2), 64'(0));
    chk({tag, "_rsp_data2"}, rsp_data2, 64'(0));
    chk({tag, "_fetch_cnt2"}, 64'(fetch_cnt2), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    #1;
    rstn = 1'b1;
    mon_en = 1'b1;

    for (int a = 0; a < DEPTH; a++) load(10'(a), $urandom());
    load(10'd0, 32'h0050_0093);
    load(10'd1, 32'h0010_0113);
    load(10'd2, 32'h0020_81B3);
    load(10'd3, 32'h0000_0013);

    // Basic fetch
    fetch(32'h8);
    drain();

    // Backpressure with a same-address load during the hold, then back-to-back release
    rsp_ready = 1'b0;
    fetch(32'h8);
    req_pc = 32'hC;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_req_ready", 64'(req_ready1), 64'(0));
      tick();
      if (i == 0) begin
        ld_en = 1'b1;
        ld_addr = 10'd2;
        ld_data = 32'hDEAD_BEEF;
      end else begin
        ld_en = 1'b0;
      end
    end
    rsp_ready = 1'b1;
    fetch(32'hC);
    chk("release_tries", 64'(last_tries), 64'(1));
    fetch(32'h10);
    chk("b2b_tries_a", 64'(last_tries), 64'(1));
    fetch(32'h8);
    chk("b2b_tries_b", 64'(last_tries), 64'(1));
    drain();

    // Error decode and window edges
    fetch(32'h6);
    fetch(32'(4 * DEPTH));
    fetch(32'hFFFF_FFFC);
    fetch(32'h4);
    fetch(32'hFFC);
    fetch(32'hFF8);
    drain();

    // Load wins over a simultaneous request; request goes the following cycle with new data
    ld_en = 1'b1;
    ld_addr = 10'd5;
    ld_data = 32'h0123_4567;
    req_valid = 1'b1;
    req_pc = 32'h14;
    @(negedge clk);
    chk("prio_req_ready", 64'(req_ready1), 64'(0));
    tick();
    ld_en = 1'b0;
    fetch(32'h14);
    chk("prio_next_cycle", 64'(last_tries), 64'(1));
    drain();

    // Asynchronous reset with a response pending; storage must survive
    rsp_ready = 1'b0;
    fetch(32'h8);
    req_valid = 1'b0;
    mon_en = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check_reset("mid");
    q1.delete();
    q2.delete();
    n_acc = 0;
    tick();
    rstn = 1'b1;
    rsp_ready = 1'b1;
    mon_en = 1'b1;
    fetch(32'h8);
    drain();

    // Randomised mix of loads, good/misaligned/out-of-range/last-word fetches and random backpressure
    bp_en = 1'b1;
    for (int it = 0; it < 400; it++) begin
      int op;
      logic [31:0] pc;
      op = int'($urandom_range(0, 9));
      if (op < 3) begin
        load(10'($urandom_range(0, DEPTH - 1)), $urandom());
      end else begin
        case (op)
          3: pc = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
          4: pc = 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
          5: pc = 32'((DEPTH - 1) * 4);
          default: pc = 32'($urandom_range(0, DEPTH - 1)) << 2;
        endcase
        fetch(pc);
        if ($urandom_range(0, 3) == 0) req_valid = 1'b0;
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
